fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage and the IF/ID and ID/EX pipeline registers. It generates the PC hold, the IF/ID capture enable and the flush strobes. It also generates the branch redirect select and target. Inputs are the load-use, branch-redirect, data-memory-busy and debug-halt conditions. A boot/run/wait/halt state machine and saturating stall/flush event counters live in the same block.

## Interface
Parameters:
- BOOT_CYCLES, 2, cycles PC/IF are held after reset release (≥1)
- CNT_W, 32, event counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- ID_rs1_addr, ID_rs2_addr  in  5  source registers of instruction in ID
- ID_rs1_used, ID_rs2_used  in  1  source actually read by ID instruction
- EX_rd_addr  in  5  destination of instruction in EX
- EX_mem_rd  in  1  instruction in EX is a load
- EX_br_taken  in  1  EX resolved a taken branch/jump (redirect)
- EX_br_target  in  32  redirect target
- MEM_busy  in  1  data memory not ready; whole pipeline freezes
- halt_req  in  1  debug halt request, level
- pc_en  out  1  1 = PC register loads next PC
- IF_stall_en  out  1  1 = IF/ID register captures; 0 = hold
- IF_rst_n  out  1  0 = clear IF/ID on next edge
- ID_flush_n  out  1  0 = insert bubble into ID/EX on next edge
- pc_sel  out  1  1 = next PC is pc_imm
- pc_imm  out  32  redirect target
- ctrl_state  out  3  current FSM state encoding
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- States: BOOT, RUN, MEM_WAIT, HALT.
- BOOT: boot counter counts BOOT_CYCLES cycles. pc_en=0, IF_stall_en=0, IF_rst_n=0, ID_flush_n=0. When the count completes, go to RUN.
- Condition priority in RUN, highest first: MEM_busy, then EX_br_taken, then load-use, then halt_req.
- MEM_busy=1 in RUN, same cycle: pc_en=0, IF_stall_en=0, IF_rst_n=1, ID_flush_n=1. The pipeline is frozen and nothing is flushed. Next state is MEM_WAIT.
- MEM_WAIT: same outputs as the MEM_busy=1 case. Return to RUN in the first cycle MEM_busy=0; that cycle evaluates the RUN rules. EX_br_taken is ignored while MEM_busy=1. EX is frozen, so the branch re-presents afterwards.
- Redirect, when EX_br_taken=1 and MEM_busy=0:
  - pc_sel=1, pc_imm=EX_br_target, pc_en=1.
  - IF_rst_n=0 and ID_flush_n=0, which squashes both wrong-path instructions.
  - flush_cnt increments.
- Load-use hazard: EX_mem_rd=1 and EX_rd_addr≠0, with (ID_rs1_used and rs1 matches EX_rd_addr) or (ID_rs2_used and rs2 matches).
  - Response: pc_en=0, IF_stall_en=0, ID_flush_n=0, IF_rst_n=1 for exactly one cycle.
  - stall_cnt increments.
  - A redirect in the same cycle overrides the stall and the stall count.
- halt_req=1 in RUN with no higher condition: go to HALT. That cycle is a normal advance.
- HALT: pc_en=0 and IF_stall_en=0, so IF/ID is held; ID_flush_n=0 drains bubbles. Return to RUN when halt_req=0. MEM_busy in HALT is ignored, because only bubbles issue.
- Idle RUN: pc_en=1, IF_stall_en=1, IF_rst_n=1, ID_flush_n=1, pc_sel=0.
- pc_imm is EX_br_target whenever pc_sel=1, otherwise 0.
- Counters saturate at all-ones and do not wrap.

## Timing
- Outputs are Mealy: combinational from the registered state and the current inputs, so they act on the same edge as fetch.
- The state register, boot counter and event counters are the only flops.
- Redirect latency: target is in the PC one edge after EX_br_taken. The first right-path instruction is in IF/ID two edges after.
- Reset values, with rst_ni=0 asynchronously:
  - State BOOT, boot counter 0, stall_cnt=0, flush_cnt=0.
  - pc_en=0, IF_stall_en=0, IF_rst_n=0, ID_flush_n=0, pc_sel=0, pc_imm=0.
- Reset mid-operation, in any state, returns immediately to BOOT and the full BOOT_CYCLES hold is repeated.
- Any input event during BOOT is ignored and not counted.
- ctrl_state encodings: BOOT=0, RUN=1, MEM_WAIT=2, HALT=3.

## Structure
- Package fetch_ctrl_pkg holds:
  - the state enum (ctrl_state_e, 3-bit) and its encodings
  - the x0 register constant (REG_ZERO=5'd0)
  - the default CNT_W
- Sub-module sat_counter (parameter W; inputs inc and clear). It is instantiated twice, for stall_cnt and flush_cnt.
- Load-use comparison and output decode are inline combinational logic.

## Test plan
- Reset release, BOOT_CYCLES=2: ctrl_state=0 for 2 cycles with pc_en=0 and IF_rst_n=0, then ctrl_state=1 with pc_en=1 and IF_stall_en=1.
- Load-use: EX_mem_rd=1, EX_rd_addr=5, ID_rs2_addr=5, ID_rs2_used=1 for one cycle.
  - Required that cycle: pc_en=0, IF_stall_en=0, ID_flush_n=0, IF_rst_n=1; stall_cnt goes 0→1.
  - Repeat with EX_rd_addr=0: no stall.
- Redirect together with load-use: EX_br_taken=1, EX_br_target=32'h0000_0040 plus a hazard.
  - Required: pc_sel=1, pc_imm=32'h40, IF_rst_n=0, ID_flush_n=0, pc_en=1.
  - Counters: flush_cnt=1, stall_cnt unchanged.
- MEM_busy held 3 cycles with EX_br_taken=1 throughout.
  - Required: ctrl_state=2 and all enables 0 with no flush; flush_cnt increments only in the first cycle after MEM_busy falls.
- halt_req for 4 cycles: HALT with ID_flush_n=0 and pc_en=0; RUN one cycle after halt_req drops. Then assert rst_ni=0 mid-HALT: outputs go to reset values immediately and counters read 0.
- Saturation: preload stall_cnt to all-ones (CNT_W=4, 15 hazards), then apply one more hazard: stall_cnt stays 15.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencing controller
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        MEM_WAIT = 3'd2,
        HALT     = 3'd3
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
//   clk_i  : clock
//   rst_ni : async active-low reset, clears count
//   inc    : count one event this cycle
//   clear  : synchronous clear, wins over inc
//   cnt    : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage and IF/ID, ID/EX sequencing with boot/run/wait/halt FSM
//   clk_i, rst_ni                : clock, async active-low reset
//   ID_rs1/rs2_addr, _used       : sources read by the instruction in ID
//   EX_rd_addr, EX_mem_rd        : destination / load flag of the instruction in EX
//   EX_br_taken, EX_br_target    : redirect request and target from EX
//   MEM_busy                     : data memory stall, freezes the whole pipe
//   halt_req                     : debug halt level
//   pc_en, IF_stall_en           : PC load / IF/ID capture enables
//   IF_rst_n, ID_flush_n         : IF/ID clear / ID/EX bubble strobes (active low)
//   pc_sel, pc_imm               : redirect select and target
//   ctrl_state                   : FSM state encoding
//   stall_cnt, flush_cnt         : saturating load-use stall / redirect counters
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic [4:0]       EX_rd_addr,
    input  logic             EX_mem_rd,
    input  logic             EX_br_taken,
    input  logic [31:0]      EX_br_target,
    input  logic             MEM_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             IF_stall_en,
    output logic             IF_rst_n,
    output logic             ID_flush_n,
    output logic             pc_sel,
    output logic [31:0]      pc_imm,
    output logic [2:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);

    ctrl_state_e   state, state_nx;
    logic [BW-1:0] boot_cnt;
    logic          hazard, boot_done, stall_inc, flush_inc;

    assign hazard = EX_mem_rd && (EX_rd_addr != REG_ZERO) &&
                    ((ID_rs1_used && ID_rs1_addr == EX_rd_addr) ||
                     (ID_rs2_used && ID_rs2_addr == EX_rd_addr));
    assign boot_done  = boot_cnt == BW'(BOOT_CYCLES - 1);
    assign ctrl_state = state;
    assign pc_imm     = pc_sel ? EX_br_target : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= BOOT;
            boot_cnt <= '0;
        end else begin
            state    <= state_nx;
            boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
        end
    end

    // MEM_WAIT with MEM_busy=1 yields exactly the RUN freeze response, so
    // both states share one rule set; leaving MEM_WAIT falls out naturally.
    always_comb begin
        state_nx    = state;
        pc_en       = 1'b0;
        IF_stall_en = 1'b0;
        IF_rst_n    = 1'b0;
        ID_flush_n  = 1'b0;
        pc_sel      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            BOOT: state_nx = boot_done ? RUN : BOOT;
            RUN, MEM_WAIT: begin
                if (MEM_busy) begin
                    IF_rst_n   = 1'b1;
                    ID_flush_n = 1'b1;
                    state_nx   = MEM_WAIT;
                end else if (EX_br_taken) begin
                    pc_en       = 1'b1;
                    IF_stall_en = 1'b1;
                    pc_sel      = 1'b1;
                    flush_inc   = 1'b1;
                    state_nx    = RUN;
                end else if (hazard) begin
                    IF_rst_n  = 1'b1;
                    stall_inc = 1'b1;
                    state_nx  = RUN;
                end else begin
                    pc_en       = 1'b1;
                    IF_stall_en = 1'b1;
                    IF_rst_n    = 1'b1;
                    ID_flush_n  = 1'b1;
                    state_nx    = halt_req ? HALT : RUN;
                end
            end
            HALT: begin
                IF_rst_n = 1'b1;
                state_nx = halt_req ? HALT : RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (stall_inc),
        .clear (state == BOOT),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (flush_inc),
        .clear (state == BOOT),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  ID_rs1_addr, ID_rs2_addr, EX_rd_addr;
    logic        ID_rs1_used, ID_rs2_used, EX_mem_rd, EX_br_taken;
    logic [31:0] EX_br_target;
    logic        MEM_busy, halt_req;
    logic        pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel;
    logic [31:0] pc_imm;
    logic [2:0]  ctrl_state;
    logic [3:0]  stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ID_rs1_addr (ID_rs1_addr),
        .ID_rs2_addr (ID_rs2_addr),
        .ID_rs1_used (ID_rs1_used),
        .ID_rs2_used (ID_rs2_used),
        .EX_rd_addr  (EX_rd_addr),
        .EX_mem_rd   (EX_mem_rd),
        .EX_br_taken (EX_br_taken),
        .EX_br_target(EX_br_target),
        .MEM_busy    (MEM_busy),
        .halt_req    (halt_req),
        .pc_en       (pc_en),
        .IF_stall_en (IF_stall_en),
        .IF_rst_n    (IF_rst_n),
        .ID_flush_n  (ID_flush_n),
        .pc_sel      (pc_sel),
        .pc_imm      (pc_imm),
        .ctrl_state  (ctrl_state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // inputs change 1 after the edge, outputs are sampled 2 after the edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #1 chk(tag, {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, exp);
    endtask

    task automatic set_hazard(input logic on);
        EX_mem_rd   = on;
        EX_rd_addr  = on ? 5'd5 : 5'd0;
        ID_rs2_addr = on ? 5'd5 : 5'd0;
        ID_rs2_used = on;
    endtask

    initial begin
        rst_ni = 1'b0;
        {ID_rs1_addr, ID_rs2_addr, EX_rd_addr} = '0;
        {ID_rs1_used, ID_rs2_used, EX_mem_rd, EX_br_taken} = '0;
        EX_br_target = 32'h0;
        MEM_busy = 1'b0;
        halt_req = 1'b0;
        #2;
        chk("rst_state", ctrl_state, 0);
        chk("rst_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00000);
        chk("rst_imm", pc_imm, 0);
        chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
        cyc(); cyc();
        rst_ni = 1'b1;
        #1 chk("boot0_state", ctrl_state, 0);
        chk("boot0_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00000);
        cyc();
        EX_br_taken = 1'b1;
        EX_br_target = 32'h80;
        set_hazard(1'b1);
        #1 chk("boot1_state", ctrl_state, 0);
        chk("boot1_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00000);
        chk("boot1_imm", pc_imm, 0);
        cyc();
        EX_br_taken = 1'b0;
        set_hazard(1'b0);
        #1 chk("run_state", ctrl_state, 1);
        chk("run_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b11110);
        chk("boot_nocount", {stall_cnt, flush_cnt}, 0);

        cyc();
        set_hazard(1'b1);
        chk_ctl("lu_ctl", 5'b00100);
        chk("lu_cnt_before", stall_cnt, 0);
        cyc();
        EX_rd_addr = 5'd0;
        ID_rs2_addr = 5'd0;
        chk("lu_cnt_after", stall_cnt, 1);
        chk_ctl("lu_x0_ctl", 5'b11110);
        cyc();
        chk("lu_x0_cnt", stall_cnt, 1);
        ID_rs1_addr = 5'd7;
        ID_rs1_used = 1'b1;
        EX_rd_addr = 5'd7;
        chk_ctl("lu_rs1_ctl", 5'b00100);
        cyc();
        ID_rs1_used = 1'b0;
        chk("lu_rs1_cnt", stall_cnt, 2);

        set_hazard(1'b1);
        EX_br_taken = 1'b1;
        EX_br_target = 32'h0000_0040;
        chk_ctl("br_ctl", 5'b11001);
        chk("br_imm", pc_imm, 32'h40);
        cyc();
        set_hazard(1'b0);
        chk("br_flush", flush_cnt, 1);
        chk("br_stall", stall_cnt, 2);

        MEM_busy = 1'b1;
        chk_ctl("mb0_ctl", 5'b00110);
        chk("mb0_imm", pc_imm, 0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            #1 chk("mb_state", ctrl_state, 2);
            chk("mb_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00110);
            chk("mb_flush", flush_cnt, 1);
        end
        cyc();
        MEM_busy = 1'b0;
        #1 chk("mbx_state", ctrl_state, 2);
        chk("mbx_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b11001);
        chk("mbx_flush", flush_cnt, 1);
        cyc();
        EX_br_taken = 1'b0;
        chk("mbx_flush_after", flush_cnt, 2);
        chk("mbx_run", ctrl_state, 1);

        halt_req = 1'b1;
        chk_ctl("h0_ctl", 5'b11110);
        for (int i = 1; i < 4; i++) begin
            cyc();
            if (i == 2) MEM_busy = 1'b1;
            #1 chk("h_state", ctrl_state, 3);
            chk("h_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00100);
        end
        cyc();
        MEM_busy = 1'b0;
        halt_req = 1'b0;
        #1 chk("hx_state", ctrl_state, 3);
        cyc();
        #1 chk("hx_run", ctrl_state, 1);
        halt_req = 1'b1;
        cyc(); cyc();
        #1 chk("h2_state", ctrl_state, 3);
        rst_ni = 1'b0;
        #1 chk("mrst_state", ctrl_state, 0);
        chk("mrst_ctl", {pc_en, IF_stall_en, IF_rst_n, ID_flush_n, pc_sel}, 5'b00000);
        chk("mrst_cnt", {stall_cnt, flush_cnt}, 0);
        halt_req = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
        #1 chk("reboot_state", ctrl_state, 0);
        cyc();
        #1 chk("reboot_run", ctrl_state, 1);

        for (int i = 0; i < 15; i++) begin
            set_hazard(1'b1);
            cyc();
            set_hazard(1'b0);
            cyc();
        end
        chk("sat_full", stall_cnt, 15);
        set_hazard(1'b1);
        chk_ctl("sat_ctl", 5'b00100);
        cyc();
        set_hazard(1'b0);
        chk("sat_hold", stall_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
